// File: rtl/matmul_job_arbiter_if.sv
// Requester + engine handshake bundle for the matmul job arbiter.
// Purely combinational wiring; no latency of its own.
// Requesters hold req until their done pulse; the engine signals completion with eng_done.
interface matmul_job_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int MB      = 4,
  parameter int KB      = 4,
  parameter int NB      = 4,
  parameter int CW      = 16
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*(MB+1)-1:0]   req_m;
  logic [NUM_REQ*(KB+1)-1:0]   req_k;
  logic [NUM_REQ*(NB+1)-1:0]   req_n;
  logic [NUM_REQ-1:0]          gnt;
  logic [NUM_REQ-1:0]          req_done;
  logic [NUM_REQ-1:0]          req_err;
  logic                        eng_start;
  logic                        eng_done;
  logic [MB:0]                 eng_m;
  logic [KB:0]                 eng_k;
  logic [NB:0]                 eng_n;
  logic                        eng_abort;
  logic                        busy;
  logic [CW-1:0]               job_cycles;

  // Requesters and the engine together form the master side.
  modport master (
    output req, req_m, req_k, req_n, eng_done,
    input  gnt, req_done, req_err, eng_start, eng_m, eng_k, eng_n,
           eng_abort, busy, job_cycles
  );

  // The arbiter answers requests and drives the engine controls.
  modport slave (
    input  req, req_m, req_k, req_n, eng_done,
    output gnt, req_done, req_err, eng_start, eng_m, eng_k, eng_n,
           eng_abort, busy, job_cycles
  );
endinterface

// File: rtl/matmul_job_arbiter.sv
// Round-robin sharing of one matmul engine between NUM_REQ requesters, with dim check and watchdog.
// Latency: grant 1 cycle after req, start 1 cycle after grant, done pulse 1 cycle after eng_done.
// Requesters wait (req held) while another job owns the engine; all outputs registered.
module matmul_job_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_M   = 16,
  parameter int MAX_K   = 16,
  parameter int MAX_N   = 16,
  parameter int MB      = $clog2(MAX_M),
  parameter int KB      = $clog2(MAX_K),
  parameter int NB      = $clog2(MAX_N),
  parameter int TIMEOUT = 65535,
  parameter int CW      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matmul_job_arbiter_if.slave  bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [MB:0]   M_LIM   = (MB+1)'(MAX_M);
  localparam logic [KB:0]   K_LIM   = (KB+1)'(MAX_K);
  localparam logic [NB:0]   N_LIM   = (NB+1)'(MAX_N);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      rr_ptr, rr_ptr_nxt, owner, owner_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt, done_q, done_nxt, err_q, err_nxt;
  logic               start_q, start_nxt, abort_q, abort_nxt, busy_q, busy_nxt;
  logic [MB:0]        m_q, m_nxt;
  logic [KB:0]        k_q, k_nxt;
  logic [NB:0]        n_q, n_nxt;
  logic [CW-1:0]      cnt, cnt_nxt, jc_q, jc_nxt;

  logic [MB:0]        m_arr [NUM_REQ];
  logic [KB:0]        k_arr [NUM_REQ];
  logic [NB:0]        n_arr [NUM_REQ];
  logic               found, dims_ok;
  logic [PW-1:0]      win, idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign m_arr[g] = bus.req_m[g*(MB+1) +: MB+1];
    assign k_arr[g] = bus.req_k[g*(KB+1) +: KB+1];
    assign n_arr[g] = bus.req_n[g*(NB+1) +: NB+1];
  end

  // Pointer that follows requester w in the rotation.
  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
    return (int'(w) == NUM_REQ - 1) ? '0 : w + 1'b1;
  endfunction

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Winner's dimensions must lie in 1..MAX for the engine to accept them.
  always_comb begin
    dims_ok = (m_arr[win] != '0) && (m_arr[win] <= M_LIM) &&
              (k_arr[win] != '0) && (k_arr[win] <= K_LIM) &&
              (n_arr[win] != '0) && (n_arr[win] <= N_LIM);
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    gnt_nxt    = gnt_q;
    done_nxt   = '0;
    err_nxt    = '0;
    start_nxt  = 1'b0;
    abort_nxt  = 1'b0;
    m_nxt      = m_q;
    k_nxt      = k_q;
    n_nxt      = n_q;
    cnt_nxt    = cnt;
    jc_nxt     = jc_q;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = win;
          if (dims_ok) begin
            m_nxt     = m_arr[win];
            k_nxt     = k_arr[win];
            n_nxt     = n_arr[win];
            gnt_nxt   = NUM_REQ'(1) << win;
            state_nxt = LAUNCH;
          end else begin
            // Bad job is answered directly; the engine never sees it.
            done_nxt[win] = 1'b1;
            err_nxt[win]  = 1'b1;
            rr_ptr_nxt    = ptr_after(win);
            state_nxt     = RESP;
          end
        end
      end
      LAUNCH: begin
        start_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = BUSY;
      end
      BUSY: begin
        cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
        // Done takes priority over a watchdog expiring in the same cycle.
        if (bus.eng_done) begin
          jc_nxt          = cnt + 1'b1;
          done_nxt[owner] = 1'b1;
          gnt_nxt         = '0;
          rr_ptr_nxt      = ptr_after(owner);
          state_nxt       = RESP;
        end else if (cnt == TO_LAST) begin
          abort_nxt       = 1'b1;
          done_nxt[owner] = 1'b1;
          err_nxt[owner]  = 1'b1;
          gnt_nxt         = '0;
          rr_ptr_nxt      = ptr_after(owner);
          state_nxt       = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      cnt     <= '0;
      jc_q    <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      owner   <= owner_nxt;
      gnt_q   <= gnt_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      start_q <= start_nxt;
      abort_q <= abort_nxt;
      busy_q  <= busy_nxt;
      m_q     <= m_nxt;
      k_q     <= k_nxt;
      n_q     <= n_nxt;
      cnt     <= cnt_nxt;
      jc_q    <= jc_nxt;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.req_done   = done_q;
  assign bus.req_err    = err_q;
  assign bus.eng_start  = start_q;
  assign bus.eng_abort  = abort_q;
  assign bus.eng_m      = m_q;
  assign bus.eng_k      = k_q;
  assign bus.eng_n      = n_q;
  assign bus.busy       = busy_q;
  assign bus.job_cycles = jc_q;

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Directed bench for matmul_job_arbiter with a response scoreboard.
// Expected responses are queued as jobs are issued and popped when req_done fires.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_matmul_job_arbiter;
  localparam int NR = 2;
  localparam int DW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  matmul_job_arbiter_if #(.NUM_REQ(NR), .MB(4), .KB(4), .NB(4), .CW(16)) bus ();

  matmul_job_arbiter #(
    .NUM_REQ(NR), .MAX_M(16), .MAX_K(16), .MAX_N(16),
    .TIMEOUT(100), .CW(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit err;
    bit abort;
    int cycles;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_jc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input bit err, input bit abort, input int cycles);
    exp_t e;
    e.idx = idx; e.err = err; e.abort = abort; e.cycles = cycles;
    sb.push_back(e);
  endtask

  task automatic set_dims(input int r, input int m, input int k, input int n);
    bus.req_m[r*DW +: DW] = DW'(m);
    bus.req_k[r*DW +: DW] = DW'(k);
    bus.req_n[r*DW +: DW] = DW'(n);
  endtask

  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.eng_start) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  // Called at the falling edge where eng_start is first seen; done is sampled d edges after start rose.
  task automatic run_engine(input int d);
    @(negedge clk);
    check("start_one_cycle", bus.eng_start, 0);
    repeat (d - 2) @(negedge clk);
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.eng_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_jc = 0;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_onehot0", $onehot0(bus.gnt), 1);
      if (bus.req_done != '0) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", bus.req_done, 0);
        end else begin
          mon_e = sb.pop_front();
          check("done_owner", bus.req_done, 1 << mon_e.idx);
          check("err_flag", bus.req_err, mon_e.err ? (1 << mon_e.idx) : 0);
          check("abort_flag", bus.eng_abort, mon_e.abort);
          check("job_cycles", bus.job_cycles, mon_e.cycles);
        end
      end else begin
        check("err_without_done", bus.req_err, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k;
    bus.req = '0; bus.req_m = '0; bus.req_k = '0; bus.req_n = '0; bus.eng_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", bus.gnt, 0);
    check("rst_req_done", bus.req_done, 0);
    check("rst_req_err", bus.req_err, 0);
    check("rst_eng_start", bus.eng_start, 0);
    check("rst_eng_abort", bus.eng_abort, 0);
    check("rst_eng_m", bus.eng_m, 0);
    check("rst_eng_k", bus.eng_k, 0);
    check("rst_eng_n", bus.eng_n, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_job_cycles", bus.job_cycles, 0);
    rst_n = 1'b1;

    // Single job, M=2 K=3 N=2, engine done 40 cycles after start
    @(negedge clk);
    set_dims(0, 2, 3, 2);
    bus.req = 2'b01;
    @(negedge clk);
    check("single_gnt", bus.gnt, 2'b01);
    check("single_busy", bus.busy, 1);
    check("single_no_early_start", bus.eng_start, 0);
    @(negedge clk);
    check("single_start", bus.eng_start, 1);
    check("single_m", bus.eng_m, 2);
    check("single_k", bus.eng_k, 3);
    check("single_n", bus.eng_n, 2);
    push(0, 0, 0, 40);
    run_engine(40);
    check("single_done_seen", bus.req_done, 2'b01);
    bus.req = '0;
    exp_jc = 40;
    @(negedge clk);
    check("single_busy_after", bus.busy, 0);
    check("single_gnt_after", bus.gnt, 0);
    check("single_jc_held", bus.job_cycles, 40);

    // Stray eng_done while idle
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.eng_done = 1'b0;
    check("stray_busy", bus.busy, 0);
    check("stray_done", bus.req_done, 0);
    @(negedge clk);
    check("stray_busy2", bus.busy, 0);

    // Round robin with both requesters held
    do_reset();
    set_dims(0, 4, 4, 4);
    set_dims(1, 3, 5, 7);
    bus.req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      int w;
      w = j % 2;
      wait_start("rr_start");
      check("rr_gnt", bus.gnt, 1 << w);
      check("rr_m", bus.eng_m, (w == 1) ? 3 : 4);
      check("rr_n", bus.eng_n, (w == 1) ? 7 : 4);
      push(w, 0, 0, 5 + j);
      run_engine(5 + j);
      if (j == 3) bus.req = '0;
    end
    exp_jc = 8;
    @(negedge clk);

    // Illegal dims: K=0, then M=17, both on requester 1
    for (int j = 0; j < 2; j++) begin
      if (j == 0) set_dims(1, 3, 0, 3);
      else        set_dims(1, 17, 3, 3);
      push(1, 1, 0, exp_jc);
      bus.req = 2'b10;
      @(negedge clk);
      check("bad_done", bus.req_done, 2'b10);
      check("bad_err", bus.req_err, 2'b10);
      check("bad_gnt", bus.gnt, 0);
      check("bad_start", bus.eng_start, 0);
      bus.req = '0;
      @(negedge clk);
      check("bad_start_after", bus.eng_start, 0);
      check("bad_busy_after", bus.busy, 0);
    end

    // Watchdog: engine never answers
    set_dims(0, 2, 2, 2);
    bus.req = 2'b01;
    push(0, 1, 1, exp_jc);
    wait_start("wd_start");
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.req_done != '0) begin
        k = i;
        break;
      end
    end
    check("wd_latency", k, 100);
    check("wd_abort", bus.eng_abort, 1);
    bus.req = '0;
    @(negedge clk);
    check("wd_abort_pulse", bus.eng_abort, 0);
    check("wd_idle", bus.busy, 0);
    check("wd_jc_kept", bus.job_cycles, exp_jc);

    // Done arriving on the last watchdog cycle counts as success
    bus.req = 2'b01;
    wait_start("col_start");
    push(0, 0, 0, 100);
    run_engine(100);
    check("col_no_err", bus.req_err, 0);
    check("col_no_abort", bus.eng_abort, 0);
    bus.req = '0;
    exp_jc = 100;
    @(negedge clk);

    // Reset during BUSY, then a normal job that drops req mid-flight
    bus.req = 2'b01;
    wait_start("rst_job_start");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", bus.gnt, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_start", bus.eng_start, 0);
    check("mid_rst_abort", bus.eng_abort, 0);
    check("mid_rst_m", bus.eng_m, 0);
    check("mid_rst_jc", bus.job_cycles, 0);
    bus.req = '0;
    exp_jc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_dims(0, 5, 6, 7);
    set_dims(1, 2, 2, 2);
    bus.req = 2'b11;
    @(negedge clk);
    check("post_rst_gnt_rr0", bus.gnt, 2'b01);
    @(negedge clk);
    check("post_rst_start", bus.eng_start, 1);
    check("post_rst_k", bus.eng_k, 6);
    bus.req = '0;
    push(0, 0, 0, 12);
    run_engine(12);
    check("post_rst_done", bus.req_done, 2'b01);
    @(negedge clk);
    check("post_rst_jc", bus.job_cycles, 12);
    check("post_rst_idle", bus.busy, 0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matmul_job_arbiter.md
Name: matmul_job_arbiter

Overview:
Shares one MatrixMulEngine_BRAM instance between NUM_REQ requesters, for example the conv-im2col path and the FC layer path.
- Arbitrates round-robin and latches the winner's M/K/N dimensions.
- Issues a one-cycle start pulse to the engine and waits for its done.
- Returns a per-requester done/err response.
- Rejects illegal dimensions without touching the engine.
- Aborts hung jobs with a watchdog and reports the cycle count of the last completed job.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
MAX_M, 16, engine max rows of A
MAX_K, 16, engine max inner dimension
MAX_N, 16, engine max cols of B
MB, $clog2(MAX_M), M index bits; dims are MB+1 wide
KB, $clog2(MAX_K), K index bits; dims are KB+1 wide
NB, $clog2(MAX_N), N index bits; dims are NB+1 wide
TIMEOUT, 65535, max BUSY cycles before abort
CW, 16, width of cycle counter / job_cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester job request, held until its done
req_m  in  NUM_REQ*(MB+1)  packed M per requester (requester i at [i*(MB+1)+:MB+1])
req_k  in  NUM_REQ*(KB+1)  packed K, same packing
req_n  in  NUM_REQ*(NB+1)  packed N, same packing
gnt  out  NUM_REQ  one-hot grant; owner may drive the engine BRAMs
req_done  out  NUM_REQ  one-cycle completion pulse to owner
req_err  out  NUM_REQ  one-cycle error flag, coincident with req_done (bad dims or timeout)
eng_start  out  1  one-cycle start to engine
eng_done  in  1  engine done pulse
eng_m  out  MB+1  latched M to engine
eng_k  out  KB+1  latched K to engine
eng_n  out  NB+1  latched N to engine
eng_abort  out  1  one-cycle abort pulse (engine soft-reset hook)
busy  out  1  high in any state other than IDLE
job_cycles  out  CW  LAUNCH-to-done cycle count of last successful job

Behaviour:
- Reset (rst_n=0, async): state=IDLE, rr_ptr=0, all outputs 0 (gnt, req_done, req_err, eng_start, eng_abort, eng_m/k/n, job_cycles, busy).
- States: IDLE, LAUNCH, BUSY, RESP. All outputs are registered.
- IDLE:
  - If any req, pick the first set req at or after rr_ptr (wrap modulo NUM_REQ) as winner w.
  - Dimensions are valid if each of m, k, n is ≥1 and ≤ its MAX.
  - Valid: latch eng_m/k/n, gnt<=onehot(w), go to LAUNCH.
  - Invalid: req_done[w]<=1, req_err[w]<=1, no gnt, no eng_start, rr_ptr<=w+1, go to RESP.
- LAUNCH: eng_start<=1 (exactly one cycle), cycle counter cnt<=0, go to BUSY.
- BUSY:
  - eng_start<=0; cnt increments by 1 per cycle, saturating.
  - On eng_done: job_cycles<=cnt+1, req_done[w]<=1, gnt<=0, rr_ptr<=w+1, go to RESP.
  - Else if cnt==TIMEOUT-1: eng_abort<=1, req_done[w]<=1, req_err[w]<=1, gnt<=0, rr_ptr<=w+1, go to RESP. job_cycles is unchanged.
  - eng_done and timeout in the same cycle: eng_done wins, and the job counts as success.
- RESP: lasts one cycle. req_done/req_err/eng_abort are high only in this cycle. The requester must drop req on the edge that samples req_done. Go to IDLE.
- Latency: req high at edge t gives gnt at t+1, eng_start at t+2, and eng_start high for one cycle. eng_done sampled at edge d gives req_done visible d+1..d+2. The earliest next grant is at the edge after RESP.
- eng_m/k/n stay stable from LAUNCH until the next grant; they are never changed in BUSY.
- Dimension or req changes while granted are ignored until the job completes.
- req dropped mid-job: the job still completes and the done pulse is still issued.
- eng_done seen outside BUSY is ignored.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 jobs.
- gnt is always one-hot or zero. At most one req_done bit is high per cycle.

Test Plan:
- Single job, correct timing: req0 with M=2,K=3,N=2; engine model asserts done 40 cycles after start. Required: gnt=01 one cycle after req, eng_start 1-cycle pulse, eng_m/k/n=2/3/2, req_done[0] pulse, job_cycles=40, busy low after RESP.
- Round-robin: req0 and req1 held continuously. Required: grant order 0,1,0,1; no back-to-back re-grant of the same requester while the other is requesting.
- Illegal dimensions: req1 with K=0, then req1 with M=17 (MAX_M=16). Required: no eng_start, req_done[1] and req_err[1] pulse together, gnt stays 00.
- Watchdog: TIMEOUT=100, engine never asserts done. Required: eng_abort and req_err[0] pulse 100 cycles after entering BUSY, state back to IDLE, job_cycles unchanged.
- Done/timeout collision: eng_done arrives in the cycle cnt==TIMEOUT-1. Required: success response, req_err=0, eng_abort=0.
- Reset mid-job: assert rst_n low during BUSY. Required: all outputs 0 immediately, rr_ptr=0; after release, the next req0 is serviced normally.
